// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Shared datapath width and 4-bit ALU operation codes.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_PASS = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_SLT  = 4'b1010,
    ALU_MAX  = 4'b1011
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ----------------------------------------------------------------------------
// Module : fwd_mux
// Brief  : Per-operand RAW bypass select; EX/MEM beats MEM/WB, x0 never bypassed.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b0
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   stored,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_wen,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_wen,
  input  logic [XLEN-1:0]   mwb_result,
  output logic [XLEN-1:0]   fwd_data
);

  logic nonzero;
  logic exm_hit;
  logic mwb_hit;

  assign nonzero = |addr;
  assign exm_hit = FWD_EN && exm_wen && (exm_rd == addr) && nonzero;
  assign mwb_hit = FWD_EN && mwb_wen && (mwb_rd == addr) && nonzero;

  always_comb begin
    fwd_data = stored;
    if (exm_hit)      fwd_data = exm_result;
    else if (mwb_hit) fwd_data = mwb_result;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with ALU operand select. Define
//          ID_EX_FWD_EN to enable EX/MEM and MEM/WB result forwarding.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int XLEN   = alu_pkg::XLEN,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_srca_pc,
  input  logic              in_srcb_imm,
  input  logic [3:0]        in_alucontrol,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   num1,
  output logic [XLEN-1:0]   num2,
  output logic [3:0]        alucontrol,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] rd_addr,
  output logic              reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_wen,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_wen,
  input  logic [XLEN-1:0]   mwb_result
);

  import alu_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              valid;
  logic [XLEN-1:0]   pc;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic              srca_pc;
  logic              srcb_imm;
  logic [3:0]        alu_op;
  logic [REG_AW-1:0] rd;
  logic              wen;

  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  logic              load;

  assign in_ready = !valid || out_ready;
  assign load     = in_valid && in_ready;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .addr(rs1_addr), .stored(rs1_data),
    .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_wen(mwb_wen), .mwb_result(mwb_result),
    .fwd_data(rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .addr(rs2_addr), .stored(rs2_data),
    .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_wen(mwb_wen), .mwb_result(mwb_result),
    .fwd_data(rs2_fwd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= '0;
      rs1_addr <= '0;
      rs2_addr <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      imm      <= '0;
      srca_pc  <= 1'b0;
      srcb_imm <= 1'b0;
      alu_op   <= ALU_PASS;
      rd       <= '0;
      wen      <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= in_pc;
      rs1_addr <= in_rs1_addr;
      rs2_addr <= in_rs2_addr;
      rs1_data <= in_rs1_data;
      rs2_data <= in_rs2_data;
      imm      <= in_imm;
      srca_pc  <= in_srca_pc;
      srcb_imm <= in_srcb_imm;
      alu_op   <= in_alucontrol;
      rd       <= in_rd_addr;
      wen      <= in_reg_write;
    end else if (valid && out_ready) begin
      valid <= 1'b0;
    end else if (valid && FWD_EN) begin
      // Stalled: latch the bypassed value so it survives once the producer retires.
      rs1_data <= rs1_fwd;
      rs2_data <= rs2_fwd;
    end
  end

  assign out_valid  = valid;
  assign num1       = srca_pc  ? pc  : rs1_fwd;
  assign num2       = srcb_imm ? imm : rs2_fwd;
  assign store_data = rs2_fwd;
  assign alucontrol = alu_op;
  assign rd_addr    = rd;
  assign reg_write  = wen;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// Module : tb_id_ex_stage
// Brief  : Directed self-checking bench for id_ex_stage (ID_EX_FWD_EN aware).
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  import alu_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready;
  logic [XLEN-1:0]   in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic              in_srca_pc, in_srcb_imm, in_reg_write;
  logic [3:0]        in_alucontrol;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   num1, num2, store_data;
  logic [3:0]        alucontrol;
  logic [REG_AW-1:0] rd_addr;
  logic              reg_write;
  logic [REG_AW-1:0] exm_rd, mwb_rd;
  logic              exm_wen, mwb_wen;
  logic [XLEN-1:0]   exm_result, mwb_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_srca_pc(in_srca_pc), .in_srcb_imm(in_srcb_imm),
    .in_alucontrol(in_alucontrol), .in_rd_addr(in_rd_addr),
    .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .num1(num1), .num2(num2), .alucontrol(alucontrol),
    .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write),
    .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_wen(mwb_wen), .mwb_result(mwb_result)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] pc, input logic [REG_AW-1:0] a1,
                       input logic [XLEN-1:0] d1, input logic [REG_AW-1:0] a2,
                       input logic [XLEN-1:0] d2, input logic [XLEN-1:0] im,
                       input logic spc, input logic simm, input logic [3:0] op,
                       input logic [REG_AW-1:0] rd);
    in_pc = pc; in_rs1_addr = a1; in_rs1_data = d1;
    in_rs2_addr = a2; in_rs2_data = d2; in_imm = im;
    in_srca_pc = spc; in_srcb_imm = simm; in_alucontrol = op;
    in_rd_addr = rd; in_reg_write = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, ALU_PASS, '0);
    in_reg_write = 1'b0;
    exm_rd = '0; exm_wen = 1'b0; exm_result = '0;
    mwb_rd = '0; mwb_wen = 1'b0; mwb_result = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu",   {28'd0, alucontrol}, 32'd0);
    check("rst_num1",  num1, 32'd0);
    check("rst_num2",  num2, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Load ADD with immediate operand
    drive(32'h100, 5'd1, 32'd5, 5'd2, 32'h55, 32'd7, 1'b0, 1'b1, ALU_ADD, 5'd9);
    in_valid = 1'b1;
    tick();
    // Present a second instruction while downstream stalls
    drive(32'h104, 5'd6, 32'd100, 5'd7, 32'h66, 32'd200, 1'b0, 1'b1, ALU_SUB, 5'd10);
    out_ready = 1'b0;
    settle();
    check("ld_valid", {31'd0, out_valid}, 32'd1);
    check("ld_num1",  num1, 32'd5);
    check("ld_num2",  num2, 32'd7);
    check("ld_alu",   {28'd0, alucontrol}, 32'd1);
    check("ld_sdata", store_data, 32'h55);
    check("ld_rd",    {27'd0, rd_addr}, 32'd9);
    check("ld_ready", {31'd0, in_ready}, 32'd0);

    // Backpressure for 3 cycles: held
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_num1",  num1, 32'd5);
      check("bp_alu",   {28'd0, alucontrol}, 32'd1);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("bp_new_valid", {31'd0, out_valid}, 32'd1);
    check("bp_new_num1",  num1, 32'd100);
    check("bp_new_num2",  num2, 32'd200);
    check("bp_new_alu",   {28'd0, alucontrol}, 32'd2);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // PC / rs2 operand selection
    drive(32'h1000, 5'd1, 32'h11, 5'd2, 32'h22, 32'h33, 1'b1, 1'b0, ALU_XOR, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    check("sel_num1", num1, 32'h1000);
    check("sel_num2", num2, 32'h22);
    tick();

    // Flush together with a load: nothing captured
    drive(32'h40, 5'd1, 32'h9, 5'd2, 32'h8, 32'h7, 1'b1, 1'b1, ALU_OR, 5'd4);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    settle();
    check("flush_ld_valid", {31'd0, out_valid}, 32'd0);

    // Flush of a held, stalled entry
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    settle();
    check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    settle();
    check("flush_held_valid", {31'd0, out_valid}, 32'd0);

`ifdef ID_EX_FWD_EN
    // EX/MEM wins over MEM/WB
    drive(32'h200, 5'd3, 32'h11, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 5'd5);
    in_valid = 1'b1;
    exm_rd = 5'd3; exm_wen = 1'b1; exm_result = 32'hAA;
    mwb_rd = 5'd3; mwb_wen = 1'b1; mwb_result = 32'hBB;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    settle();
    check("fwd_exm_prio", num1, 32'hAA);
    exm_wen = 1'b0;
    settle();
    check("fwd_mwb", num1, 32'hBB);
    out_ready = 1'b1;
    mwb_wen = 1'b0;
    tick();

    // x0 is never forwarded
    drive(32'h204, 5'd0, 32'h77, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, ALU_ADD, 5'd5);
    in_valid = 1'b1;
    exm_rd = 5'd0; exm_wen = 1'b1; exm_result = 32'hAA;
    tick();
    in_valid = 1'b0;
    settle();
    check("fwd_x0", num1, 32'h77);
    exm_wen = 1'b0;
    tick();

    // Stall refresh keeps a value that left MEM/WB
    drive(32'h208, 5'd0, 32'h0, 5'd4, 32'h9, 32'h0, 1'b0, 1'b0, ALU_ADD, 5'd6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    mwb_rd = 5'd4; mwb_wen = 1'b1; mwb_result = 32'h1234;
    settle();
    check("refresh_live", store_data, 32'h1234);
    tick();
    mwb_wen = 1'b0;
    settle();
    check("refresh_sdata", store_data, 32'h1234);
    check("refresh_num2",  num2, 32'h1234);
    tick();
    check("refresh_hold", store_data, 32'h1234);
    out_ready = 1'b1;
    tick();
    check("refresh_drain", {31'd0, out_valid}, 32'd0);
`else
    // Without forwarding the bypass inputs are ignored, even across a stall
    drive(32'h200, 5'd3, 32'h11, 5'd4, 32'h9, 32'h0, 1'b0, 1'b0, ALU_ADD, 5'd5);
    in_valid = 1'b1;
    exm_rd = 5'd3; exm_wen = 1'b1; exm_result = 32'hAA;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    mwb_rd = 5'd4; mwb_wen = 1'b1; mwb_result = 32'h1234;
    settle();
    check("nofwd_num1",  num1, 32'h11);
    check("nofwd_sdata", store_data, 32'h9);
    tick();
    exm_wen = 1'b0; mwb_wen = 1'b0;
    settle();
    check("nofwd_stall_sdata", store_data, 32'h9);
    out_ready = 1'b1;
    tick();
    check("nofwd_drain", {31'd0, out_valid}, 32'd0);
`endif

    // Reset overrides a pending load
    drive(32'h300, 5'd1, 32'h5, 5'd2, 32'h6, 32'h7, 1'b0, 1'b1, ALU_MAX, 5'd7);
    in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    settle();
    check("rst_prio_valid", {31'd0, out_valid}, 32'd0);
    check("rst_prio_alu",   {28'd0, alucontrol}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
